itype_issue_unit: RTL
=====================

// Module: itype_issue_unit
// PURPOSE
//  Driver side of the I-type ALU interface. Accepts 32-bit MIPS I-type instruction words over a
//  valid/ready handshake, decodes them, reads a 32x32 register file, and drives the opcode and
//  operands into the combinational ALU. Captures the ALU result and flags, writes the result back
//  to rt, resolves BEQ/BNE, and keeps the PC. Sits between instruction fetch and the I-type ALU.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  TRAP_ON_OV 1              1: ADDI overflow suppresses writeback and raises Exception
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   synchronous, active-high reset
//  InstrValid     in   1   InstrWord is valid
//  InstrReady     out  1   unit can accept an instruction (high only in IDLE)
//  InstrWord      in   32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:0] imm16
//  AluOPCode      out  6   opcode to ALU
//  AluRs          out  32  operand A to ALU
//  AluRt          out  32  operand B to ALU (see operand rules)
//  AluImmediate   out  32  extended immediate to ALU
//  AluResult      in   32  ALU result
//  AluZero        in   1   ALU zero flag
//  AluCarryOut    in   1   ALU carry flag
//  AluOverFlow    in   1   ALU overflow flag
//  PC             out  32  address of next instruction
//  Done           out  1   one-cycle pulse when an instruction retires
//  BranchTaken    out  1   valid with Done: BEQ/BNE redirected PC
//  Exception      out  1   valid with Done: overflow trap or illegal opcode
//  DbgAddr        in   5   debug register read address
//  DbgData        out  32  combinational read of register DbgAddr
// BEHAVIOUR
//  Reset: FSM=IDLE, PC=RESET_PC, all registers 0, InstrReady=1, Done/BranchTaken/Exception=0,
//   Alu* outputs 0. Reset mid-instruction aborts it with no writeback and no PC change.
//  FSM IDLE->DECODE->EXEC->WB->IDLE; one instruction in flight, fixed 3-cycle latency
//   (accept edge to Done pulse). IDLE: InstrReady=1; accept on InstrValid&InstrReady, latch word.
//  DECODE: read reg[rs], reg[rt]; reg[0] reads 0 always. Build imm32:
//   ADDI/ADDIU/SLTI/SLTIU/BEQ/BNE sign-extend imm16; ANDI/ORI zero-extend; LUI {imm16,16'h0}.
//  EXEC: Alu* registered outputs held stable all cycle; AluRt = imm32 for immediate ops (so ALU
//   overflow check compares correct signs), AluRt = reg[rt] for BEQ/BNE. Sample ALU outputs at
//   end of EXEC.
//  WB: Done=1 for exactly one cycle.
//   ADDI/ADDIU/ANDI/ORI/LUI/SLTI/SLTIU: reg[rt]<=AluResult unless rt==0 or trap; PC<=PC+4.
//   ADDI with AluOverFlow & TRAP_ON_OV: no write, Exception=1, PC<=PC+4.
//   BEQ taken iff AluZero; BNE taken iff !AluZero; taken: PC<=PC+4+(sext(imm16)<<2),
//   BranchTaken=1; else PC<=PC+4. No register write. PC arithmetic wraps mod 2^32.
//   Any other opcode: illegal, no write, Exception=1, PC<=PC+4.
//  InstrValid outside IDLE is ignored (not consumed). AluCarryOut is ignored for architectural state.
//  DbgData reflects writes from the cycle after WB.
// TESTING
//  reset; ADDI $1,$0,5 (0x20010005) -> Done 3 cycles after accept, reg1=5, PC=4, Exception=0
//  LUI $2,0x1234 then ORI $2,$2,0x5678 -> reg2=0x12345678; ANDI $3,$2,0xFFFF -> reg3=0x5678
//  reg1=0x7FFFFFFF; ADDI $4,$1,1 -> Exception=1, reg4 unchanged; ADDIU $4,$1,1 -> reg4=0x80000000
//  reg1=5: SLTI $5,$1,-1 -> reg5=0; SLTIU $5,$1,-1 -> reg5=1; ADDI $0,$0,7 -> reg0 stays 0
//  PC=0x10, reg1=reg2: BEQ $1,$2,-2 -> BranchTaken=1, PC=0x0C; BNE same -> PC=0x14; PC=0xFFFFFFFC
//   non-branch -> PC=0
//  opcode 0x3F -> Exception=1, no write; assert reset in EXEC -> no Done, regs/PC at reset values

Source files
------------

// File: rtl/itype_issue_unit.sv
// Issue/writeback controller for MIPS I-type instructions driving an external combinational ALU.
// One instruction in flight: IDLE -> DECODE -> EXEC -> WB, with Done pulsed during WB.
module itype_issue_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          TRAP_ON_OV = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        InstrValid,
    output logic        InstrReady,
    input  logic [31:0] InstrWord,
    output logic [5:0]  AluOPCode,
    output logic [31:0] AluRs,
    output logic [31:0] AluRt,
    output logic [31:0] AluImmediate,
    input  logic [31:0] AluResult,
    input  logic        AluZero,
    input  logic        AluCarryOut,
    input  logic        AluOverFlow,
    output logic [31:0] PC,
    output logic        Done,
    output logic        BranchTaken,
    output logic        Exception,
    input  logic [4:0]  DbgAddr,
    output logic [31:0] DbgData
);

    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] instr;
    logic [31:0] regs [32];
    logic [31:0] result_q;
    logic        write_q;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm32;
    logic [31:0] branch_target;
    logic        is_alu_op;
    logic        is_branch;
    logic        taken;
    logic        trap;

    // The carry flag carries no architectural meaning for this instruction subset.
    logic unused_inputs;
    assign unused_inputs = AluCarryOut;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign imm16  = instr[15:0];

    assign rs_val  = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val  = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign DbgData = (DbgAddr == 5'd0) ? 32'd0 : regs[DbgAddr];

    assign branch_target = PC + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        imm32     = {{16{imm16[15]}}, imm16};
        is_alu_op = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OP_ANDI, OP_ORI: begin
                imm32     = {16'h0000, imm16};
                is_alu_op = 1'b1;
            end
            OP_LUI: begin
                imm32     = {imm16, 16'h0000};
                is_alu_op = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: is_alu_op = 1'b1;
            OP_BEQ, OP_BNE:                       is_branch = 1'b1;
            default: ;
        endcase
    end

    assign taken = ((opcode == OP_BEQ) && AluZero) || ((opcode == OP_BNE) && !AluZero);
    assign trap  = TRAP_ON_OV && (opcode == OP_ADDI) && AluOverFlow;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            instr        <= '0;
            PC           <= RESET_PC;
            InstrReady   <= 1'b1;
            Done         <= 1'b0;
            BranchTaken  <= 1'b0;
            Exception    <= 1'b0;
            AluOPCode    <= '0;
            AluRs        <= '0;
            AluRt        <= '0;
            AluImmediate <= '0;
            result_q     <= '0;
            write_q      <= 1'b0;
            // NOTE: the register file is architecturally cleared by reset, so the array is reset too.
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (InstrValid) begin
                        instr      <= InstrWord;
                        InstrReady <= 1'b0;
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    AluOPCode    <= opcode;
                    AluRs        <= rs_val;
                    // Immediate ops see imm32 on operand B so the ALU's overflow check uses its sign.
                    AluRt        <= is_branch ? rt_val : imm32;
                    AluImmediate <= imm32;
                    state        <= EXEC;
                end
                EXEC: begin
                    result_q    <= AluResult;
                    write_q     <= is_alu_op && !trap && (rt != 5'd0);
                    Done        <= 1'b1;
                    BranchTaken <= is_branch && taken;
                    Exception   <= trap || !(is_alu_op || is_branch);
                    state       <= WB;
                end
                WB: begin
                    if (write_q) begin
                        regs[rt] <= result_q;
                    end
                    PC          <= BranchTaken ? branch_target : PC + 32'd4;
                    Done        <= 1'b0;
                    BranchTaken <= 1'b0;
                    Exception   <= 1'b0;
                    write_q     <= 1'b0;
                    InstrReady  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
